// File: rtl/i2c_slave_read_bytes.sv
// I2C slave byte receiver: assembles BYTE_NUM bytes (MSB first) into one parallel word,
// with input synchroniser, glitch filter, ACK/NACK drive and mid-byte START/STOP detection.
module i2c_slave_read_bytes #(
    parameter int BYTE_NUM   = 2,
    parameter int FILTER_LEN = 2,
    parameter int ACK_EN     = 1,
    parameter int NACK_LAST  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  go,
    input  logic                  scl,
    input  logic                  sda,
    output logic                  sda_oe,
    output logic [8*BYTE_NUM-1:0] data,
    output logic                  byte_valid,
    output logic [3:0]            byte_index,
    output logic                  busy,
    output logic                  finish,
    output logic                  error
);

    localparam int unsigned NB = BYTE_NUM;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_BIT,
        S_ACK_WAIT,
        S_ACK
    } state_t;

    // Bus inputs handled as a pair: index 0 = SCL, index 1 = SDA
    logic [1:0] raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] filt;
    logic [1:0] filt_q;
    logic [3:0] fcnt [2];

    assign raw = {sda, scl};

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1  <= '1;
            sync2  <= '1;
            filt   <= '1;
            filt_q <= '1;
            for (int unsigned i = 0; i < 2; i++) fcnt[i] <= '0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            filt_q <= filt;
            // A level change needs FILTER_LEN consecutive differing samples
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == 4'(FILTER_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 4'd1;
                end
            end
        end
    end

    logic scl_f;
    logic sda_f;
    logic scl_rise;
    logic scl_fall;
    logic sda_tog;
    logic illegal;

    assign scl_f    = filt[0];
    assign sda_f    = filt[1];
    assign scl_rise =  filt[0] & ~filt_q[0];
    assign scl_fall = ~filt[0] &  filt_q[0];
    assign sda_tog  =  filt[1] ^  filt_q[1];
    // An SDA move while SCL is steadily high is a START or STOP
    assign illegal  = sda_tog & scl_f & ~scl_rise;

    state_t                state, state_n;
    logic [2:0]            bit_cnt, bit_cnt_n;
    logic [3:0]            byte_cnt, byte_cnt_n;
    logic [6:0]            shreg, shreg_n;
    logic [8*BYTE_NUM-1:0] data_n;
    logic [3:0]            byte_index_n;
    logic                  sda_oe_n;
    logic                  busy_n;
    logic                  byte_valid_n;
    logic                  finish_n;
    logic                  error_n;
    logic [7:0]            byte_word;
    logic                  last;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            shreg      <= '0;
            data       <= '0;
            byte_index <= '0;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            byte_valid <= 1'b0;
            finish     <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            byte_cnt   <= byte_cnt_n;
            shreg      <= shreg_n;
            data       <= data_n;
            byte_index <= byte_index_n;
            sda_oe     <= sda_oe_n;
            busy       <= busy_n;
            byte_valid <= byte_valid_n;
            finish     <= finish_n;
            error      <= error_n;
        end
    end

    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        byte_cnt_n   = byte_cnt;
        shreg_n      = shreg;
        data_n       = data;
        byte_index_n = byte_index;
        sda_oe_n     = sda_oe;
        busy_n       = busy;
        byte_valid_n = 1'b0;
        finish_n     = 1'b0;
        error_n      = 1'b0;
        byte_word    = {shreg, sda_f};
        last         = (byte_cnt == 4'(BYTE_NUM - 1));

        case (state)
            S_IDLE: begin
                if (go) begin
                    state_n    = S_SYNC;
                    busy_n     = 1'b1;
                    bit_cnt_n  = '0;
                    byte_cnt_n = '0;
                end
            end
            S_SYNC: begin
                if (!scl_f) state_n = S_BIT;
            end
            S_BIT: begin
                if (illegal) begin
                    error_n  = 1'b1;
                    sda_oe_n = 1'b0;
                    busy_n   = 1'b0;
                    state_n  = S_IDLE;
                end else if (scl_rise) begin
                    shreg_n   = byte_word[6:0];
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        // First byte lands in the most significant slot
                        for (int unsigned i = 0; i < NB; i++) begin
                            if (byte_cnt == 4'(i)) data_n[8*(NB-1-i) +: 8] = byte_word;
                        end
                        byte_valid_n = 1'b1;
                        byte_index_n = byte_cnt;
                        state_n      = S_ACK_WAIT;
                    end
                end
            end
            S_ACK_WAIT: begin
                if (scl_fall) begin
                    sda_oe_n = (ACK_EN != 0) && !((NACK_LAST != 0) && last);
                    state_n  = S_ACK;
                end
            end
            S_ACK: begin
                if (scl_fall) begin
                    sda_oe_n = 1'b0;
                    if (last) begin
                        finish_n = 1'b1;
                        busy_n   = 1'b0;
                        state_n  = S_IDLE;
                    end else begin
                        byte_cnt_n = byte_cnt + 4'd1;
                        state_n    = S_BIT;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_i2c_slave_read_bytes.sv
// Scoreboard bench for i2c_slave_read_bytes: a 2-byte ACKing instance and a 4-byte
// instance that NACKs its last byte, driven by a simple bit-banged I2C master.
module tb_i2c_slave_read_bytes;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_go, a_scl, a_sda;
    logic        a_oe, a_bv, a_busy, a_fin, a_err;
    logic [15:0] a_data;
    logic [3:0]  a_idx;

    logic        b_rst, b_go, b_scl, b_sda;
    logic        b_oe, b_bv, b_busy, b_fin, b_err;
    logic [31:0] b_data;
    logic [3:0]  b_idx;

    i2c_slave_read_bytes #(.BYTE_NUM(2), .FILTER_LEN(2), .ACK_EN(1), .NACK_LAST(0)) dut_a (
        .clock(clk), .reset(a_rst), .go(a_go), .scl(a_scl), .sda(a_sda),
        .sda_oe(a_oe), .data(a_data), .byte_valid(a_bv), .byte_index(a_idx),
        .busy(a_busy), .finish(a_fin), .error(a_err)
    );

    i2c_slave_read_bytes #(.BYTE_NUM(4), .FILTER_LEN(2), .ACK_EN(1), .NACK_LAST(1)) dut_b (
        .clock(clk), .reset(b_rst), .go(b_go), .scl(b_scl), .sda(b_sda),
        .sda_oe(b_oe), .data(b_data), .byte_valid(b_bv), .byte_index(b_idx),
        .busy(b_busy), .finish(b_fin), .error(b_err)
    );

    typedef struct {
        int          kind;   // 0 byte_valid, 1 finish, 2 error
        int          idx;
        logic [31:0] word;
    } ev_t;

    ev_t         qa[$];
    ev_t         qb[$];
    logic [31:0] expw [2];
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input bit w, input int kind, input int idx);
        ev_t e;
        e.kind = kind;
        e.idx  = idx;
        e.word = expw[w];
        if (w) qb.push_back(e); else qa.push_back(e);
    endtask

    task automatic sb(input bit w, input int kind, input int idx, input logic [31:0] word);
        ev_t e;
        if ((w && qb.size() == 0) || (!w && qa.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event inst=%0d actual_kind=%0d required=none", w, kind);
        end else begin
            e = w ? qb.pop_front() : qa.pop_front();
            chk(w ? "b_event_kind" : "a_event_kind", kind, e.kind);
            if (e.kind == 0) chk(w ? "b_byte_index" : "a_byte_index", idx, e.idx);
            chk(w ? "b_event_data" : "a_event_data", word, e.word);
        end
    endtask

    always @(negedge clk) begin
        if (a_bv)  sb(0, 0, int'(a_idx), {16'h0, a_data});
        if (a_fin) sb(0, 1, 0, {16'h0, a_data});
        if (a_err) sb(0, 2, 0, {16'h0, a_data});
        if (b_bv)  sb(1, 0, int'(b_idx), b_data);
        if (b_fin) sb(1, 1, 0, b_data);
        if (b_err) sb(1, 2, 0, b_data);
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_scl(input bit w, input logic v);
        if (w) b_scl = v; else a_scl = v;
    endtask

    task automatic set_sda(input bit w, input logic v);
        if (w) b_sda = v; else a_sda = v;
    endtask

    task automatic set_go(input bit w, input logic v);
        if (w) b_go = v; else a_go = v;
    endtask

    function automatic logic get_oe(input bit w);
        return w ? b_oe : a_oe;
    endfunction

    function automatic logic get_busy(input bit w);
        return w ? b_busy : a_busy;
    endfunction

    task automatic chk_idle(input bit w);
        if (w) begin
            chk("b_rst_oe", b_oe, 0);   chk("b_rst_data", b_data, 0);
            chk("b_rst_bv", b_bv, 0);   chk("b_rst_idx", b_idx, 0);
            chk("b_rst_busy", b_busy, 0); chk("b_rst_fin", b_fin, 0);
            chk("b_rst_err", b_err, 0);
        end else begin
            chk("a_rst_oe", a_oe, 0);   chk("a_rst_data", a_data, 0);
            chk("a_rst_bv", a_bv, 0);   chk("a_rst_idx", a_idx, 0);
            chk("a_rst_busy", a_busy, 0); chk("a_rst_fin", a_fin, 0);
            chk("a_rst_err", a_err, 0);
        end
    endtask

    // One SCL clock starting and ending with SCL low; optional 1-cycle SDA glitch while high
    task automatic bit_clk(input bit w, input logic v, input bit glitch);
        clks(2); set_sda(w, v);
        clks(2); set_scl(w, 1'b1);
        if (glitch) begin
            clks(1); set_sda(w, ~v);
            clks(1); set_sda(w, v);
            clks(2);
        end else begin
            clks(4);
        end
        set_scl(w, 1'b0);
    endtask

    task automatic ack_clk(input bit w, input logic exp_oe);
        clks(2); set_sda(w, 1'b1);
        clks(2); set_scl(w, 1'b1);
        clks(2); chk(w ? "b_ack_oe" : "a_ack_oe", get_oe(w), exp_oe);
        clks(2); set_scl(w, 1'b0);
    endtask

    task automatic begin_xfer(input bit w);
        set_go(w, 1'b1); clks(1); set_go(w, 1'b0);
        clks(3);
        chk(w ? "b_busy_go" : "a_busy_go", get_busy(w), 1);
        set_sda(w, 1'b0); clks(4); set_scl(w, 1'b0);
    endtask

    task automatic send_byte(input bit w, input int k, input int n, input logic [7:0] byt,
                             input int glitch_bit, input bit go_mid);
        logic [31:0] t;
        t = expw[w];
        t[8*(n-1-k) +: 8] = byt;
        expw[w] = t;
        push(w, 0, k);
        for (int i = 0; i < 8; i++) begin
            bit_clk(w, byt[7-i], glitch_bit == i);
            if (go_mid && i == 2) begin
                set_go(w, 1'b1); clks(1); set_go(w, 1'b0);
            end
        end
    endtask

    task automatic stop_cond(input bit w);
        clks(2); set_sda(w, 1'b0);
        clks(2); set_scl(w, 1'b1);
        clks(2); set_sda(w, 1'b1);
        clks(4);
    endtask

    task automatic xfer(input bit w, input int n, input logic [31:0] word, input bit nack_last,
                        input int glitch_at, input bit go_mid);
        logic [7:0] byt;
        begin_xfer(w);
        for (int k = 0; k < n; k++) begin
            byt = word[8*(n-1-k) +: 8];
            send_byte(w, k, n, byt, (glitch_at / 8 == k) ? glitch_at % 8 : -1, go_mid && k == 1);
            if (k == n - 1) push(w, 1, 0);
            ack_clk(w, !(nack_last && k == n - 1));
        end
        stop_cond(w);
        clks(4);
        chk(w ? "b_busy_end" : "a_busy_end", get_busy(w), 0);
        chk(w ? "b_oe_end" : "a_oe_end", get_oe(w), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst = 1'b1; a_go = 1'b0; a_scl = 1'b1; a_sda = 1'b1;
        b_rst = 1'b1; b_go = 1'b0; b_scl = 1'b1; b_sda = 1'b1;
        expw[0] = '0;
        expw[1] = '0;
        clks(3);
        chk_idle(0);
        chk_idle(1);
        a_rst = 1'b0; b_rst = 1'b0;
        clks(4);

        // Two ACKed bytes
        xfer(0, 2, 32'h0000_A53C, 1'b0, -1, 1'b0);
        chk("a_data_t1", a_data, 16'hA53C);

        // SDA glitch while SCL is high on byte 0, bit 3
        xfer(0, 2, 32'h0000_5AC3, 1'b0, 3, 1'b0);

        // go pulsed mid-transfer must be ignored
        xfer(0, 2, 32'h0000_817E, 1'b0, -1, 1'b1);
        clks(6);
        chk("a_busy_after_go_mid", a_busy, 0);

        // STOP after 3 bits of byte 1
        begin_xfer(0);
        send_byte(0, 0, 2, 8'hE1, -1, 1'b0);
        ack_clk(0, 1'b1);
        push(0, 2, 0);
        bit_clk(0, 1'b1, 1'b0);
        bit_clk(0, 1'b0, 1'b0);
        bit_clk(0, 1'b1, 1'b0);
        stop_cond(0);
        clks(4);
        chk("a_busy_err", a_busy, 0);
        chk("a_data_err", a_data, 16'hE17E);

        // Reset while in the ACK clock
        begin_xfer(0);
        send_byte(0, 0, 2, 8'h66, -1, 1'b0);
        clks(2); set_sda(0, 1'b1);
        clks(2); set_scl(0, 1'b1);
        clks(1);
        chk("a_oe_pre_rst", a_oe, 1);
        a_rst = 1'b1;
        clks(1);
        chk_idle(0);
        a_rst = 1'b0;
        expw[0] = '0;
        clks(1); set_scl(0, 1'b0);
        stop_cond(0);
        clks(4);
        xfer(0, 2, 32'h0000_1234, 1'b0, -1, 1'b0);
        chk("a_data_post_rst", a_data, 16'h1234);

        // Four bytes, last NACKed
        xfer(1, 4, 32'h1357_9BDF, 1'b1, -1, 1'b0);
        chk("b_data_t2", b_data, 32'h1357_9BDF);

        clks(10);
        chk("a_sb_empty", qa.size(), 0);
        chk("b_sb_empty", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
